// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Exposes the opcode enum, FSM state enum and iteration-count helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    function automatic int md_k_mul(input int width, input int mul_bits);
        return width / mul_bits;
    endfunction

    function automatic int md_k_div(input int width);
        return width;
    endfunction

endpackage

// File: rtl/muldiv_unit_iter.sv
// One combinational iteration of the shared mul/div datapath.
// Ports: mode (0 mul, 1 div), acc/x/y/rem in and next-step values out.
module muldiv_unit_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic               mode,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0]   y_i,
    input  logic [WIDTH:0]     rem_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] x_o,
    output logic [WIDTH-1:0]   y_o,
    output logic [WIDTH:0]     rem_o
);

    // Mul: acc = product, x = shifted multiplicand, y = remaining multiplier.
    // Div: acc[W-1:0] = dividend shifting into quotient, x[W-1:0] = divisor.
    logic [2*WIDTH-1:0] pp;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     dvs;
    logic               ge;

    always_comb begin
        pp     = '0;
        rem_sh = '0;
        dvs    = '0;
        ge     = 1'b0;
        acc_o  = acc_i;
        x_o    = x_i;
        y_o    = y_i;
        rem_o  = rem_i;
        if (!mode) begin
            for (int j = 0; j < MUL_BITS; j++) begin
                if (y_i[j]) pp = pp + (x_i << j);
            end
            acc_o = acc_i + pp;
            x_o   = x_i << MUL_BITS;
            y_o   = y_i >> MUL_BITS;
        end else begin
            rem_sh = {rem_i[WIDTH-1:0], acc_i[WIDTH-1]};
            dvs    = {1'b0, x_i[WIDTH-1:0]};
            ge     = (rem_sh >= dvs);
            rem_o  = ge ? (rem_sh - dvs) : rem_sh;
            acc_o  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with valid/ready in and out.
// Ports: clk, resetn, flush, in_valid/in_ready/op/a/b, out_valid/out_ready/hi/lo, busy.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW    = $clog2(WIDTH + 1);
    localparam int K_MUL = md_k_mul(WIDTH, MUL_BITS);
    localparam int K_DIV = md_k_div(WIDTH);

    md_state_t          state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div, sa, sb, dz;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc_q, x_q, acc_n, x_n;
    logic [WIDTH-1:0]   y_q, y_n;
    logic [WIDTH:0]     rem_q, rem_n;

    logic               accept, step, last;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quot_c, rem_c;

    assign in_ready  = (state == MD_IDLE);
    assign out_valid = (state == MD_DONE);
    assign busy      = (state != MD_IDLE);

    assign accept = in_ready && in_valid && !flush;
    assign step   = (state == MD_BUSY) && (cnt != '0);
    // A flushed op must not overwrite the held hi/lo.
    assign last   = (state == MD_BUSY) && (cnt == '0) && !flush;

    // Signs only matter for signed ops (op[0] == 0).
    assign a_neg = !op[0] && a[WIDTH-1];
    assign b_neg = !op[0] && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign prod_c = (sa ^ sb) ? -acc_q : acc_q;
    assign quot_c = (sa ^ sb) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_c  = sa ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    muldiv_unit_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_iter (
        .mode  (is_div),
        .acc_i (acc_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .rem_i (rem_q),
        .acc_o (acc_n),
        .x_o   (x_n),
        .y_o   (y_n),
        .rem_o (rem_n)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MD_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = MD_IDLE;
        end else begin
            unique case (state)
                MD_IDLE: if (in_valid)     state_nxt = MD_BUSY;
                MD_BUSY: if (cnt == '0)    state_nxt = MD_DONE;
                MD_DONE: if (out_ready)    state_nxt = MD_IDLE;
                default:                   state_nxt = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            a_q    <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            rem_q  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            is_div <= op[1];
            sa     <= a_neg;
            sb     <= b_neg;
            dz     <= op[1] && (b == '0);
            a_q    <= a;
            rem_q  <= '0;
            if (op[1]) begin
                cnt   <= CW'(K_DIV);
                acc_q <= {{WIDTH{1'b0}}, a_mag};
                x_q   <= {{WIDTH{1'b0}}, b_mag};
                y_q   <= '0;
            end else begin
                cnt   <= CW'(K_MUL);
                acc_q <= '0;
                x_q   <= {{WIDTH{1'b0}}, a_mag};
                y_q   <= b_mag;
            end
        end else if (step) begin
            cnt   <= cnt - 1'b1;
            acc_q <= acc_n;
            x_q   <= x_n;
            y_q   <= y_n;
            rem_q <= rem_n;
        end else if (last) begin
            if (!is_div) begin
                hi <= prod_c[2*WIDTH-1:WIDTH];
                lo <= prod_c[WIDTH-1:0];
            end else if (dz) begin
                hi <= a_q;
                lo <= '1;
            end else begin
                hi <= rem_c;
                lo <= quot_c;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit (32/4 and 16/2 builds).
// Results are compared against plain 64-bit arithmetic in the bench.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush, in_valid, out_ready;
    muldiv_op_t  op;
    logic [31:0] a, b, hi, lo;
    logic        in_ready, out_valid, busy;

    logic        flush16, in_valid16, out_ready16;
    muldiv_op_t  op16;
    logic [15:0] a16, b16, hi16, lo16;
    logic        in_ready16, out_valid16, busy16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_BITS(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .hi(hi), .lo(lo), .busy(busy)
    );

    muldiv_unit #(.WIDTH(16), .MUL_BITS(2)) dut16 (
        .clk(clk), .resetn(resetn), .flush(flush16),
        .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .hi(hi16), .lo(lo16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi, lo} from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o == 2'd0) return sx * sy;
        if (o == 2'd1) return ux * uy;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
            sq = sx / sy;
            sr = sx % sy;
            return {sr[31:0], sq[31:0]};
        end
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int hold,
                         input bit drop);
        logic [63:0] e;
        int          n;
        e = model(o, x, y);
        @(negedge clk);
        op = muldiv_op_t'(o); a = x; b = y; in_valid = 1'b1;
        check("in_ready_before", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            // Requests while busy must be ignored.
            if (n < 4) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, (o[1] ? 33 : 9));
        check("hi", hi, e[63:32]);
        check("lo", lo, e[31:0]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_data", {hi, lo}, e);
        end
        @(negedge clk);
        out_ready = 1'b1; flush = drop;
        @(posedge clk); #1;
        out_ready = 1'b0; flush = 1'b0;
        check("consumed_valid", out_valid, 0);
        check("consumed_ready", in_ready, 1);
    endtask

    initial begin
        int          n, seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = MD_MULT; a = '0; b = '0;
        flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
        op16 = MD_MULT; a16 = '0; b16 = '0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_hilo", {hi, lo}, 0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(2'd0, -32'sd3, 32'd7, 0, 0);
        do_op(2'd2, -32'sd7, 32'd2, 0, 0);
        do_op(2'd3, 32'd7, 32'd0, 0, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(2'd2, -32'sd9, 32'd0, 1, 0);
        do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0);

        // Flush mid-divide.
        @(negedge clk);
        op = MD_DIV; a = 32'd100; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_valid", seen, 0);
        do_op(2'd1, 32'd2, 32'd3, 0, 0);

        // Flush beats in_valid in IDLE.
        @(negedge clk);
        op = MD_MULTU; a = 32'd5; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_vs_valid_busy", busy, 0);

        // Flush beats out_ready in DONE, then the unit still works.
        do_op(2'd3, 32'd1000, 32'd7, 2, 1);
        do_op(2'd2, 32'd1000, -32'sd7, 0, 0);

        for (int t = 0; t < 40; t++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)) - 32'd150;
                         rb = 32'($urandom_range(0, 20)) - 32'd10; end
                default: ;
            endcase
            do_op(ro, ra, rb, $urandom_range(0, 2), 0);
        end

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op = MD_MULT; a = 32'd77; b = 32'd99; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hilo", {hi, lo}, 0);
        @(negedge clk); resetn = 1'b1;
        do_op(2'd0, 32'd77, 32'd99, 0, 0);

        // 16-bit build, 2 bits per step.
        @(negedge clk);
        op16 = MD_MULT; a16 = 16'h8000; b16 = 16'h8000; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("w16_latency", n, 9);
        check("w16_hi", hi16, 16'h4000);
        check("w16_lo", lo16, 16'h0000);
        @(negedge clk); out_ready16 = 1'b1;
        @(posedge clk); #1; out_ready16 = 1'b0;
        check("w16_consumed", in_ready16, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
